// File: rtl/shift_stack_pkg.sv
// Shared types for the shift_stack data stack: operation codes, the per-cell
// select, and the {push, pop, overwrite} decoder.
package shift_stack_pkg;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_PUSH = 3'd1,
    OP_POP  = 3'd2,
    OP_OVR  = 3'd3,
    OP_POPR = 3'd4
  } stack_op_t;

  typedef enum logic [1:0] {
    SEL_HOLD = 2'd0,
    SEL_LOAD = 2'd1,
    SEL_DOWN = 2'd2,
    SEL_UP   = 2'd3
  } cell_sel_t;

  // push+pop(+overwrite) keeps depth unchanged, so it collapses to overwrite;
  // push+overwrite alone is a plain push.
  function automatic stack_op_t decode_op(input logic push, input logic pop,
                                          input logic overwrite);
    stack_op_t op;
    unique case ({push, pop, overwrite})
      3'b000:  op = OP_NOP;
      3'b100:  op = OP_PUSH;
      3'b101:  op = OP_PUSH;
      3'b010:  op = OP_POP;
      3'b001:  op = OP_OVR;
      3'b011:  op = OP_POPR;
      default: op = OP_OVR;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/shift_stack_cell.sv
// One WIDTH-bit stack cell: hold, load from data_in, take the cell above
// (shift down) or the cell below (shift up); synchronous active-high reset.
module stack_cell
  import shift_stack_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  cell_sel_t        sel,
  input  logic [WIDTH-1:0] load_data,
  input  logic [WIDTH-1:0] down_data,
  input  logic [WIDTH-1:0] up_data,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] cell_q;
  logic [WIDTH-1:0] cell_d;

  always_comb begin
    cell_d = cell_q;
    case (sel)
      SEL_LOAD: cell_d = load_data;
      SEL_DOWN: cell_d = down_data;
      SEL_UP:   cell_d = up_data;
      default:  cell_d = cell_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) cell_q <= '0;
    else       cell_q <= cell_d;
  end

  assign q = cell_q;

endmodule

// File: rtl/shift_stack.sv
// WIDTH x DEPTH shift-cell data stack with occupancy count, full/empty and
// sticky overflow/underflow. Optional peek port under SHIFT_STACK_PEEK_EN.
module shift_stack
  import shift_stack_pkg::*;
#(
  parameter  int unsigned WIDTH = 16,
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     overwrite,
  input  logic                     err_clear,
`ifdef SHIFT_STACK_PEEK_EN
  input  logic [$clog2(DEPTH)-1:0] peek_idx,
  output logic [WIDTH-1:0]         peek_data,
`endif
  output logic [WIDTH-1:0]         sr0,
  output logic [WIDTH-1:0]         sr1,
  output logic [CW-1:0]            count,
  output logic                     empty,
  output logic                     full,
  output logic                     overflow,
  output logic                     underflow
);

  logic [WIDTH-1:0] cell_q [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             ovf_set, unf_set;
  cell_sel_t        top_sel, rest_sel;
  stack_op_t        op;

  always_comb begin
    op       = decode_op(push, pop, overwrite);
    count_d  = count_q;
    top_sel  = SEL_HOLD;
    rest_sel = SEL_HOLD;
    ovf_set  = 1'b0;
    unf_set  = 1'b0;
    case (op)
      OP_PUSH: begin
        if (count_q < CW'(DEPTH)) begin
          top_sel  = SEL_LOAD;
          rest_sel = SEL_DOWN;
          count_d  = count_q + CW'(1);
        end else begin
          ovf_set = 1'b1;
        end
      end
      OP_POP: begin
        if (count_q != '0) begin
          top_sel  = SEL_UP;
          rest_sel = SEL_UP;
          count_d  = count_q - CW'(1);
        end else begin
          unf_set = 1'b1;
        end
      end
      OP_OVR: begin
        if (count_q != '0) top_sel = SEL_LOAD;
        else               unf_set = 1'b1;
      end
      OP_POPR: begin
        if (count_q >= CW'(2)) begin
          top_sel  = SEL_LOAD;
          rest_sel = SEL_UP;
          count_d  = count_q - CW'(1);
        end else begin
          unf_set = 1'b1;
        end
      end
      default: ;
    endcase
    // A new violation in the same cycle as err_clear leaves the flag set.
    overflow_d  = ovf_set | (overflow_q & ~err_clear);
    underflow_d = unf_set | (underflow_q & ~err_clear);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_cell
    logic [WIDTH-1:0] down_w;
    logic [WIDTH-1:0] up_w;
    if (i == 0) begin : g_top
      assign down_w = '0;
    end else begin : g_mid
      assign down_w = cell_q[i-1];
    end
    // The bottom cell refills with zero so vacated entries always read 0.
    if (i == DEPTH - 1) begin : g_bot
      assign up_w = '0;
    end else begin : g_up
      assign up_w = cell_q[i+1];
    end

    stack_cell #(.WIDTH(WIDTH)) u_cell (
      .clk       (clk),
      .reset     (reset),
      .sel       ((i == 0) ? top_sel : rest_sel),
      .load_data (data_in),
      .down_data (down_w),
      .up_data   (up_w),
      .q         (cell_q[i])
    );
  end

`ifdef SHIFT_STACK_PEEK_EN
  always_comb begin
    peek_data = '0;
    if (CW'(peek_idx) < count_q) peek_data = cell_q[peek_idx];
  end
`endif

  assign sr0       = cell_q[0];
  assign sr1       = cell_q[1];
  assign count     = count_q;
  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(DEPTH));
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule
